// File: rtl/i2s_pkg.sv
// Shared I2S definitions: receiver FSM states and lrclk channel levels (also used by i2s_tx).
package i2s_pkg;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_rx_state_t;

  localparam logic I2S_LEFT  = 1'b0;
  localparam logic I2S_RIGHT = 1'b1;

  // Width of a counter that must hold the values 0..slot_max inclusive.
  function automatic int cnt_w(input int slot_max);
    return $clog2(slot_max + 1);
  endfunction

endpackage

// File: rtl/i2s_rx_deser.sv
// One channel slot deserializer: MSB-first shift register with a saturating bit counter.
// Flags the shift that lands the final sample bit and whether the slot is still short of DW bits.
module i2s_rx_deser #(
  parameter int DW       = 24,
  parameter int SLOT_MAX = 32,
  parameter int CW       = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift,
  input  logic          clr,
  input  logic          sdi,
  output logic [DW-1:0] word_nxt,
  output logic          last,
  output logic          short_slot
);

  localparam logic [CW-1:0] CNT_DW   = CW'(DW);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SLOT_MAX);

  logic [DW-1:0] word;
  logic [CW-1:0] bit_cnt;

  // Word as it stands once the current bit has been shifted in.
  assign word_nxt   = {word[DW-2:0], sdi};
  assign last       = (bit_cnt == CNT_LAST);
  assign short_slot = (bit_cnt < CNT_DW);

  always_ff @(posedge clk) begin
    if (!rst) begin
      word    <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      bit_cnt <= '0;
    end else if (shift) begin
      if (bit_cnt < CNT_DW)  word    <= word_nxt;
      if (bit_cnt < CNT_MAX) bit_cnt <= bit_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sclk/lrclk/sdi in the clk domain and emits one stereo pair per frame
// on valid/ready. Define I2S_RX_SYNC_EN to put SYNC_STAGES-flop synchronizers on the serial inputs.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DW          = 24,
  parameter int SLOT_MAX    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk,
  input  logic          lrclk,
  input  logic          sdi,
  output logic [DW-1:0] l_sample,
  output logic [DW-1:0] r_sample,
  output logic          valid,
  input  logic          ready,
  output logic          overflow,
  output logic          frame_err
);

  localparam int CW = cnt_w(SLOT_MAX);

  logic sclk_s, lrclk_s, sdi_s;

`ifdef I2S_RX_SYNC_EN
  logic [SYNC_STAGES-1:0][2:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_pipe <= '0;
    end else begin
      sync_pipe[0] <= {sclk, lrclk, sdi};
      for (int i = 1; i < SYNC_STAGES; i++) sync_pipe[i] <= sync_pipe[i-1];
    end
  end

  assign {sclk_s, lrclk_s, sdi_s} = sync_pipe[SYNC_STAGES-1];
`else
  assign sclk_s  = sclk;
  assign lrclk_s = lrclk;
  assign sdi_s   = sdi;
`endif

  i2s_rx_state_t state;
  logic          sclk_q, lrclk_q;
  logic          rise, lr_edge, clr, commit;
  logic [DW-1:0] left_sh;
  logic          left_ok;

  logic [1:0]         shift, last, short_slot;
  logic [1:0][DW-1:0] word_nxt;

  assign rise    = sclk_s & ~sclk_q;
  assign lr_edge = lrclk_s != lrclk_q;
  // The bit sampled on an lrclk edge is the previous slot's LSB; it only restarts the counters.
  assign clr     = rise & lr_edge;

  // Channel 0 deserializes the left slot, channel 1 the right slot.
  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    localparam i2s_rx_state_t SLOT_ST = (ch == 0) ? LEFT : RIGHT;

    assign shift[ch] = rise & ~lr_edge & (state == SLOT_ST);

    i2s_rx_deser #(
      .DW       (DW),
      .SLOT_MAX (SLOT_MAX),
      .CW       (CW)
    ) u_deser (
      .clk        (clk),
      .rst        (rst),
      .shift      (shift[ch]),
      .clr        (clr),
      .sdi        (sdi_s),
      .word_nxt   (word_nxt[ch]),
      .last       (last[ch]),
      .short_slot (short_slot[ch])
    );
  end

  // A pair commits on the rise that lands the right LSB, provided this frame's left word was good.
  assign commit = shift[1] & last[1] & left_ok;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ALIGN;
      sclk_q    <= 1'b0;
      lrclk_q   <= I2S_LEFT;
      left_sh   <= '0;
      left_ok   <= 1'b0;
      l_sample  <= '0;
      r_sample  <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sclk_q    <= sclk_s;
      overflow  <= 1'b0;
      frame_err <= 1'b0;

      if (commit) begin
        l_sample <= left_sh;
        r_sample <= word_nxt[1];
        valid    <= 1'b1;
        overflow <= valid & ~ready;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end

      if (rise) begin
        lrclk_q <= lrclk_s;
        case (state)
          ALIGN: begin
            if (lr_edge && lrclk_s == I2S_LEFT) state <= LEFT;
          end
          LEFT: begin
            if (lr_edge) begin
              state     <= RIGHT;
              frame_err <= short_slot[0];
            end else if (last[0]) begin
              left_sh <= word_nxt[0];
              left_ok <= 1'b1;
            end
          end
          RIGHT: begin
            if (lr_edge) begin
              state     <= LEFT;
              left_ok   <= 1'b0;
              frame_err <= short_slot[1];
            end
          end
          default: state <= ALIGN;
        endcase
      end
    end
  end

endmodule
